// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, state encoding and default response byte for the SPI subordinate
package spi_pkg;
    localparam int SPI_WIDTH = 8;
    localparam logic [SPI_WIDTH-1:0] DEFAULT_TX_BYTE = 8'hFF;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_sub_state_t;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: optional synchronizer chain followed by rise/fall detection
module spi_edge_sync #(
    parameter int   STAGES = 0,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic q, q_prev;
    if (STAGES == 0) begin : g_direct
        assign q = d;
    end else begin : g_chain
        logic [STAGES-1:0] chain;
        always_ff @(posedge clk) chain <= reset ? {STAGES{INIT}} : STAGES'({chain, d});
        assign q = chain[STAGES-1];
    end
    always_ff @(posedge clk) q_prev <= reset ? INIT : q;
    assign rise = q & ~q_prev;
    assign fall = ~q & q_prev;
endmodule

// File: rtl/spi_subordinate.sv
// spi_subordinate: SPI mode-0 endpoint with MSB-first shifting and a one-entry transmit holding register
module spi_subordinate
    import spi_pkg::*;
#(
    parameter int                   SYNC_STAGES = 0,
    parameter logic [SPI_WIDTH-1:0] DEFAULT_TX  = DEFAULT_TX_BYTE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sck,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    input  logic [SPI_WIDTH-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [SPI_WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 tx_underrun
);
    spi_sub_state_t       state;
    logic                 sck_rise, sck_fall, cs_rise, cs_fall, mosi_s, wr;
    logic [2:0]           bit_cnt;
    logic [SPI_WIDTH-1:0] tx_shift, rx_shift, hold, load_byte;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck (
        .clk(clk), .reset(reset), .d(sck), .rise(sck_rise), .fall(sck_fall));
    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
        .clk(clk), .reset(reset), .d(cs_n), .rise(cs_rise), .fall(cs_fall));

    if (SYNC_STAGES == 0) begin : g_mosi_direct
        assign mosi_s = mosi;
    end else begin : g_mosi_sync
        logic [SYNC_STAGES-1:0] mosi_chain;
        always_ff @(posedge clk) mosi_chain <= reset ? '0 : SYNC_STAGES'({mosi_chain, mosi});
        assign mosi_s = mosi_chain[SYNC_STAGES-1];
    end

    assign load_byte = tx_ready ? DEFAULT_TX : hold;
    assign wr        = tx_valid && tx_ready;
    assign miso      = (state != IDLE) && tx_shift[SPI_WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tx_shift    <= '0;
            rx_shift    <= '0;
            hold        <= '0;
            bit_cnt     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
            case (state)
                IDLE: if (cs_fall) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
                LOAD: begin
                    state       <= cs_rise ? IDLE : SHIFT;
                    busy        <= !cs_rise;
                    tx_shift    <= load_byte;
                    tx_underrun <= tx_ready;
                    tx_ready    <= 1'b1;
                    bit_cnt     <= '0;
                end
                SHIFT: if (cs_rise) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    frame_err <= bit_cnt != 3'd0;
                    bit_cnt   <= '0;
                end else if (sck_rise) begin
                    rx_shift <= {rx_shift[SPI_WIDTH-2:0], mosi_s};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data     <= {rx_shift[SPI_WIDTH-2:0], mosi_s};
                        rx_valid    <= 1'b1;
                        tx_shift    <= load_byte;
                        tx_underrun <= tx_ready;
                        tx_ready    <= 1'b1;
                    end
                end else if (sck_fall && bit_cnt != 3'd0) begin
                    tx_shift <= {tx_shift[SPI_WIDTH-2:0], 1'b0};
                end
                default: state <= IDLE;
            endcase
            // a write racing a load lands in the holding register for the following byte
            if (wr) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end
endmodule

// File: doc/spi_subordinate.md
Name: spi_subordinate

Overview:
- SPI subordinate endpoint that sits directly downstream of spi_master, on the other end of its SCK/CS/MOSI/MISO wires.
- Shifts in MOSI bytes MSB-first and presents each completed byte on a parallel valid interface.
- Shifts out MSB-first response bytes taken from a one-entry transmit holding register.
- Supports multi-byte frames while cs_n stays low; used as the loopback/peripheral model and as the register-access front end.

Parameters:
- SYNC_STAGES, 0, input synchronizer depth on sck/cs_n/mosi. 0 means same-clock connection to spi_master. When >0, the SCK half-period must be ≥ SYNC_STAGES+1 clk cycles.
- DEFAULT_TX, 8'hFF, byte shifted out when the holding register is empty at a byte load.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sck  in  1  SPI clock from master; idles low
- cs_n  in  1  chip select, active low (1 = deselected)
- mosi  in  1  serial data from master
- miso  out  1  serial data to master
- tx_data  in  8  next response byte
- tx_valid  in  1  tx_data offered
- tx_ready  out  1  holding register empty; write accepted when tx_valid && tx_ready
- rx_data  out  8  last received byte; held until the next byte completes
- rx_valid  out  1  one-cycle pulse when a byte completes
- busy  out  1  frame in progress (cs_n low)
- frame_err  out  1  one-cycle pulse: frame aborted mid-byte
- tx_underrun  out  1  one-cycle pulse: DEFAULT_TX substituted

Behaviour:
- Reset (sync, active-high; clk and reset as in the rest of the codebase): state=IDLE, miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0, frame_err=0, tx_underrun=0, bit counter=0, holding register empty. Reset wins over any concurrent event.
- Edge detect: registered copy sck_q of the (synchronized) sck.
  - rise = sck & ~sck_q; fall = ~sck & sck_q; cs_fall/cs_rise likewise on cs_n.
  - With SYNC_STAGES=0, edges are detected in the same cycle the level changes.
- State machine:
  - IDLE (cs_n high): miso=0, busy=0, edges ignored. cs_fall -> LOAD.
  - LOAD (1 cycle): tx_shift <= holding register (empty -> DEFAULT_TX with tx_underrun pulse), holding marked empty, bit_cnt <= 0, busy=1 -> SHIFT.
  - SHIFT:
    - rise: rx_shift <= {rx_shift[6:0], mosi}, bit_cnt++.
    - On the 8th rise (bit_cnt 7->0 wrap): rx_data <= {rx_shift[6:0], mosi}, rx_valid pulse next cycle, next tx byte loaded as in LOAD (same cycle as the wrap).
    - fall with bit_cnt≠0: tx_shift <= {tx_shift[6:0],1'b0}.
    - fall with bit_cnt=0: no shift (a new byte was just loaded).
    - cs_rise -> IDLE.
- miso = tx_shift[7] while in LOAD/SHIFT; 0 in IDLE. It changes only after a detected fall or a load, so it is stable through the whole SCK-high phase the master samples.
- cs_rise with bit_cnt≠0: frame_err pulse, partial rx discarded (no rx_valid), -> IDLE.
- cs_rise with bit_cnt=0: clean end, no pulse.
- cs_rise coincident with a fall: the fall is ignored.
- Holding register: write accepted when tx_valid && tx_ready; tx_ready=0 until the register is consumed by a load.
  - A write in the same cycle as a load does not bypass: the load sees empty (underrun) and the write fills the holding register for the next byte.
- rx has no back-pressure. A new byte overwrites rx_data; the consumer must take it within 8 SCK periods.
- Latency: rx_valid asserts 1 clk after the detected 8th rise (plus SYNC_STAGES).
- Width rules: bit_cnt is 3 bits and wraps naturally; no other arithmetic.

Decomposition:
- spi_pkg:
  - SPI_WIDTH=8.
  - typedef enum logic [1:0] spi_sub_state_t {IDLE, LOAD, SHIFT}.
  - DEFAULT_TX default constant.
- Sub-module spi_edge_sync: parameterised SYNC_STAGES flop chain plus rise/fall detect; instantiated for sck and cs_n (mosi is delayed only).

Test Plan:
- Back-to-back with spi_master (SYNC_STAGES=0):
  - Preload tx_data=8'h3C, master sends 8'hA5 -> rx_data=8'hA5, rx_valid pulses exactly once, master data_out=8'h3C, frame_err=0.
- No preload, master sends 8'h5A -> tx_underrun pulses once at LOAD, master receives 8'hFF, rx_data=8'h5A.
- Bench-driven 2-byte frame with cs_n held low, mosi 8'h12 then 8'h34, holding 8'hC3 then 8'h81:
  - Two rx_valid pulses with rx_data 8'h12 then 8'h34; miso bytes 8'hC3, 8'h81; tx_ready rises after each load.
- cs_n deasserted after 5 rises -> frame_err one pulse, no rx_valid, busy=0 next cycle. The next full frame of 8'hF0 is received correctly.
- reset asserted mid-byte (after 3 rises) -> all outputs at reset values next cycle. A subsequent frame of 8'h81 is received intact.
- SYNC_STAGES=2, SCK half-period 4 clk, byte 8'h96 -> rx_data=8'h96 with rx_valid 3 clk after the 8th rising edge.
